// File: rtl/wm_pkg.sv
// Shared constants for the visible-watermarking engine.
//   - APB word-address map of the parameter registers and the start of the pixel bank
//   - engine FSM state encoding
//   - fixed blend divisor (alpha/beta are percentages)
package wm_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_IWHITE = 4'd1;
  localparam logic [3:0] ADDR_NP     = 4'd2;
  localparam logic [3:0] ADDR_NW     = 4'd3;
  localparam logic [3:0] ADDR_M      = 4'd4;
  localparam logic [3:0] ADDR_BTHR   = 4'd5;
  localparam logic [3:0] ADDR_AMIN   = 4'd6;
  localparam logic [3:0] ADDR_AMAX   = 4'd7;
  localparam logic [3:0] ADDR_BMIN   = 4'd8;
  localparam logic [3:0] ADDR_BMAX   = 4'd9;
  localparam int         ADDR_IMG    = 10;

  localparam int BLEND_DIV = 100;

  typedef enum logic [2:0] {
    S_IDLE, S_STAT, S_DIV, S_COEF, S_EMIT, S_DONE
  } wm_state_e;

endpackage

// File: rtl/wm_block_stats.sv
// Per-block statistics: running sum/min/max of the pixels fed on acc_en, and
// a restoring divider producing mu = floor(sum / divisor), one quotient bit
// per cycle.
//   clr        clears sum/min/max (divider result is kept)
//   acc_en/pix one pixel per cycle into the accumulators
//   div_start  loads the current sum and starts the division
//   divisor    pixels per block (B*B)
//   pix_min/pix_max/mu  block statistics, div_done 1-cycle pulse when mu valid
module wm_block_stats #(
  parameter int DW    = 8,
  parameter int SUM_W = 21,
  parameter int N_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           acc_en,
  input  logic [DW-1:0]  pix,
  input  logic           div_start,
  input  logic [N_W-1:0] divisor,
  output logic [DW-1:0]  pix_min,
  output logic [DW-1:0]  pix_max,
  output logic [DW-1:0]  mu,
  output logic           div_done
);

  localparam int CNT_W = $clog2(SUM_W + 1);

  logic [SUM_W-1:0] sum, quo;
  logic [N_W-1:0]   rem;
  logic [N_W:0]     trial;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum     <= '0;
      pix_min <= '1;
      pix_max <= '0;
    end else if (clr) begin
      sum     <= '0;
      pix_min <= '1;
      pix_max <= '0;
    end else if (acc_en) begin
      sum <= sum + SUM_W'(pix);
      if (pix < pix_min) pix_min <= pix;
      if (pix > pix_max) pix_max <= pix;
    end
  end

  // quo doubles as the dividend shift register; quotient bits enter at the
  // bottom as dividend bits leave the top. rem < divisor always holds, so
  // the trial value never needs more than N_W+1 bits.
  assign trial = {rem, quo[SUM_W-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        rem  <= '0;
        quo  <= sum;
        cnt  <= CNT_W'(SUM_W);
        busy <= 1'b1;
      end else if (busy) begin
        if (trial >= {1'b0, divisor}) begin
          rem <= N_W'(trial - {1'b0, divisor});
          quo <= {quo[SUM_W-2:0], 1'b1};
        end else begin
          rem <= trial[N_W-1:0];
          quo <= {quo[SUM_W-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy     <= 1'b0;
          div_done <= 1'b1;
        end
      end
    end
  end

  assign mu = quo[DW-1:0];

endmodule

// File: rtl/visible_watermarking.sv
// APB-programmed visible-watermarking engine.
// Parameters and the primary/watermark images are written into an internal
// bank; a start write walks the image block by block, computes per-block
// alpha/beta from the block statistics and streams blended pixels.
//   clk, rst (async, active low)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA  APB slave, no wait states
//   Pixel_Data/new_pixel  blended pixel + 1-cycle strobe
//   Image_Done            set after the last pixel, cleared by start
module visible_watermarking import wm_pkg::*; #(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20,
  parameter int Data_Depth      = 8,
  parameter int Block_Depth     = 7,
  parameter int Max_Block_Size  = 5184
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     PENABLE,
  input  logic                     PSEL,
  input  logic                     PWRITE,
  input  logic [Amba_Addr_Depth:0] PADDR,
  input  logic [Amba_Word-1:0]     PWDATA,
  output logic [Amba_Word-1:0]     PRDATA,
  output logic [Data_Depth-1:0]    Pixel_Data,
  output logic                     new_pixel,
  output logic                     Image_Done
);

  localparam int DW         = Data_Depth;
  localparam int AW         = Amba_Addr_Depth;
  localparam int SUM_W      = $clog2(Max_Block_Size * ((1 << DW) - 1) + 1);
  localparam int N_W        = 2 * DW;
  localparam int MIX_W      = 2 * DW + 1;
  localparam int BANK_DEPTH = 1 << AW;

  wm_state_e state;
  logic [DW-1:0] iwhite, np, m, bthr, amin, amax, bmin, bmax;
  logic [DW:0]   nw;

  logic                 busy, apb_wr, apb_rd, start, in_bank, is_reg;
  logic [AW:0]          bank_off;
  logic [3:0]           reg_sel;
  logic [Amba_Word-1:0] rd_val, prdata_reg;
  logic                 rd_bank;

  assign busy     = (state != S_IDLE);
  assign apb_wr   = PSEL & PENABLE & PWRITE & ~busy;
  assign apb_rd   = PSEL & PENABLE & ~PWRITE;
  assign bank_off = PADDR - (AW+1)'(ADDR_IMG);
  assign is_reg   = PADDR < (AW+1)'(ADDR_IMG);
  assign in_bank  = ~is_reg & ~bank_off[AW];
  assign reg_sel  = PADDR[3:0];
  assign start    = apb_wr & (PADDR == '0) & PWDATA[0];

  // Block walk: (bi,bj) block, (pr,pc) pixel inside it, B = blk_side
  logic [DW-1:0]          blk_side, bi, bj;
  logic [Block_Depth-1:0] pr, pc;
  logic                   issuing, rd_vld, w_ok, w_in, blk_last, div_go;
  logic [AW-1:0]          row, col, p_addr, w_addr;

  assign row      = AW'(bi) * AW'(blk_side) + AW'(pr);
  assign col      = AW'(bj) * AW'(blk_side) + AW'(pc);
  assign p_addr   = row * AW'(np) + col;
  assign w_addr   = AW'(np) * AW'(np) + row * AW'(nw) + col;
  assign w_in     = (row < AW'(nw)) && (col < AW'(nw));
  assign blk_last = (DW'(pr) == blk_side - 1'b1) && (DW'(pc) == blk_side - 1'b1);

  // Pixel bank: port A serves APB reads when idle and P reads when busy,
  // port B fetches the co-located W pixel during EMIT. Contents survive reset.
  logic [DW-1:0] mem [BANK_DEPTH];
  logic [DW-1:0] q_a, q_b;
  logic [AW-1:0] addr_a;
  logic          en_a;

  assign addr_a = busy ? p_addr : bank_off[AW-1:0];
  assign en_a   = busy ? issuing : (apb_rd & in_bank);

  always_ff @(posedge clk) begin
    if (apb_wr && in_bank) mem[bank_off[AW-1:0]] <= PWDATA[DW-1:0];
    if (en_a) q_a <= mem[addr_a];
    if (issuing && state == S_EMIT) q_b <= mem[w_addr];
  end

  // Bank reads return the RAM output directly so data lands one edge later
  assign PRDATA = rd_bank ? Amba_Word'(q_a) : prdata_reg;

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      ADDR_CTRL:   rd_val = Amba_Word'({busy, Image_Done});
      ADDR_IWHITE: rd_val = Amba_Word'(iwhite);
      ADDR_NP:     rd_val = Amba_Word'(np);
      ADDR_NW:     rd_val = Amba_Word'(nw);
      ADDR_M:      rd_val = Amba_Word'(m);
      ADDR_BTHR:   rd_val = Amba_Word'(bthr);
      ADDR_AMIN:   rd_val = Amba_Word'(amin);
      ADDR_AMAX:   rd_val = Amba_Word'(amax);
      ADDR_BMIN:   rd_val = Amba_Word'(bmin);
      ADDR_BMAX:   rd_val = Amba_Word'(bmax);
      default:     rd_val = '0;
    endcase
  end

  logic [DW-1:0] pix_min, pix_max, mu;
  logic          div_done;

  wm_block_stats #(.DW(DW), .SUM_W(SUM_W), .N_W(N_W)) u_stats (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == S_IDLE || state == S_COEF),
    .acc_en   (state == S_STAT && rd_vld),
    .pix      (q_a),
    .div_start(div_go),
    .divisor  (N_W'(blk_side) * N_W'(blk_side)),
    .pix_min  (pix_min),
    .pix_max  (pix_max),
    .mu       (mu),
    .div_done (div_done)
  );

  // Coefficients and blend
  logic [DW-1:0]    alpha, beta, a_span, w_pix, blend;
  logic [2*DW-1:0]  a_prod;
  logic [MIX_W-1:0] mix, mix_div;

  assign a_span  = amax - amin;
  assign a_prod  = (2*DW)'(a_span) * (2*DW)'(mu);
  assign w_pix   = w_ok ? q_b : '0;
  assign mix     = MIX_W'(alpha) * MIX_W'(q_a) + MIX_W'(beta) * MIX_W'(w_pix);
  assign mix_div = mix / MIX_W'(BLEND_DIV);
  assign blend   = (mix_div > MIX_W'(iwhite)) ? iwhite : mix_div[DW-1:0];

  logic unused_ok;
  assign unused_ok = ^{PWDATA[Amba_Word-1:DW+1], a_prod[DW-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      {iwhite, np, m, bthr, amin, amax, bmin, bmax} <= '0;
      nw         <= '0;
      prdata_reg <= '0;
      rd_bank    <= 1'b0;
      Pixel_Data <= '0;
      new_pixel  <= 1'b0;
      Image_Done <= 1'b0;
      blk_side   <= '0;
      bi         <= '0;
      bj         <= '0;
      pr         <= '0;
      pc         <= '0;
      issuing    <= 1'b0;
      rd_vld     <= 1'b0;
      w_ok       <= 1'b0;
      div_go     <= 1'b0;
      alpha      <= '0;
      beta       <= '0;
    end else begin
      new_pixel <= 1'b0;
      div_go    <= 1'b0;
      rd_vld    <= issuing;
      w_ok      <= w_in;

      if (apb_rd) begin
        rd_bank    <= in_bank & ~busy;
        prdata_reg <= is_reg ? rd_val : '0;
      end

      if (apb_wr && is_reg) begin
        case (reg_sel)
          ADDR_IWHITE: iwhite <= PWDATA[DW-1:0];
          ADDR_NP:     np     <= PWDATA[DW-1:0];
          ADDR_NW:     nw     <= PWDATA[DW:0];
          ADDR_M:      m      <= PWDATA[DW-1:0];
          ADDR_BTHR:   bthr   <= PWDATA[DW-1:0];
          ADDR_AMIN:   amin   <= PWDATA[DW-1:0];
          ADDR_AMAX:   amax   <= PWDATA[DW-1:0];
          ADDR_BMIN:   bmin   <= PWDATA[DW-1:0];
          ADDR_BMAX:   bmax   <= PWDATA[DW-1:0];
          default: ;
        endcase
      end

      // One bank read per cycle in block raster order
      if (issuing) begin
        if (blk_last) issuing <= 1'b0;
        if (DW'(pc) == blk_side - 1'b1) begin
          pc <= '0;
          pr <= pr + 1'b1;
        end else begin
          pc <= pc + 1'b1;
        end
      end

      case (state)
        S_IDLE: if (start) begin
          Image_Done <= 1'b0;
          rd_bank    <= 1'b0;
          bi         <= '0;
          bj         <= '0;
          pr         <= '0;
          pc         <= '0;
          blk_side   <= (m != '0) ? np / m : '0;
          // Np<M would give a zero block side; treat like an empty image
          if (np == '0 || m == '0 || np < m) state <= S_DONE;
          else begin
            state   <= S_STAT;
            issuing <= 1'b1;
          end
        end
        // Last data returns the cycle after the last issue
        S_STAT: if (!issuing && rd_vld) begin
          state  <= S_DIV;
          div_go <= 1'b1;
        end
        S_DIV: if (div_done) state <= S_COEF;
        S_COEF: begin
          alpha   <= amin + a_prod[2*DW-1:DW];
          beta    <= ((pix_max - pix_min) <= bthr) ? bmin : bmax;
          state   <= S_EMIT;
          issuing <= 1'b1;
          pr      <= '0;
          pc      <= '0;
        end
        S_EMIT: begin
          if (rd_vld) begin
            new_pixel  <= 1'b1;
            Pixel_Data <= blend;
          end
          if (!issuing && rd_vld) begin
            if (bi == m - 1'b1 && bj == m - 1'b1) state <= S_DONE;
            else begin
              state   <= S_STAT;
              issuing <= 1'b1;
              pr      <= '0;
              pc      <= '0;
              if (bj == m - 1'b1) begin
                bj <= '0;
                bi <= bi + 1'b1;
              end else begin
                bj <= bj + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          Image_Done <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_visible_watermarking.sv
// Self-checking bench for visible_watermarking: directed scenarios plus
// randomized images compared against a behavioural model of the blend.
module tb_visible_watermarking;

  localparam int AW = 20;

  logic        clk = 1'b0, rst = 1'b0;
  logic        PENABLE = 1'b0, PSEL = 1'b0, PWRITE = 1'b0;
  logic [AW:0] PADDR = '0;
  logic [15:0] PWDATA = '0;
  logic [15:0] PRDATA;
  logic [7:0]  Pixel_Data;
  logic        new_pixel, Image_Done;

  visible_watermarking dut (
    .clk(clk), .rst(rst), .PENABLE(PENABLE), .PSEL(PSEL), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .Pixel_Data(Pixel_Data), .new_pixel(new_pixel), .Image_Done(Image_Done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int got_q[$], exp_q[$];
  int p_img[256], w_img[256];
  int np, nw, m, bthr, amin, amax, bmin, bmax, iwhite;

  always @(negedge clk) if (rst && new_pixel) got_q.push_back(int'(Pixel_Data));

  task automatic apb_write(input int addr, input int data);
    @(negedge clk);
    PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = (AW+1)'(addr); PWDATA = 16'(data);
    @(negedge clk);
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input int addr, output int data);
    @(negedge clk);
    PSEL = 1; PENABLE = 1; PWRITE = 0; PADDR = (AW+1)'(addr);
    @(negedge clk);
    data = int'(PRDATA);
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic set_common();
    np = 4; nw = 4; m = 2; bthr = 20; amin = 83; amax = 96;
    bmin = 25; bmax = 31; iwhite = 255;
  endtask

  task automatic load_params();
    apb_write(1, iwhite); apb_write(2, np); apb_write(3, nw); apb_write(4, m);
    apb_write(5, bthr); apb_write(6, amin); apb_write(7, amax);
    apb_write(8, bmin); apb_write(9, bmax);
  endtask

  task automatic load_images();
    for (int i = 0; i < np*np; i++) apb_write(10 + i, p_img[i]);
    for (int i = 0; i < nw*nw; i++) apb_write(10 + np*np + i, w_img[i]);
  endtask

  // Reference: block stats, mean, coefficients and blend straight from the rules
  task automatic build_model();
    int b, sum, mn, mx, mu, alpha, beta, row, col, w, v;
    exp_q.delete();
    if (np == 0 || m == 0 || np < m) return;
    b = np / m;
    for (int bi = 0; bi < m; bi++)
      for (int bj = 0; bj < m; bj++) begin
        sum = 0; mn = 255; mx = 0;
        for (int r = 0; r < b; r++)
          for (int c = 0; c < b; c++) begin
            v = p_img[(bi*b + r)*np + bj*b + c];
            sum += v;
            if (v < mn) mn = v;
            if (v > mx) mx = v;
          end
        mu    = sum / (b*b);
        alpha = (amin + (((amax - amin) * mu) >> 8)) % 256;
        beta  = (mx - mn <= bthr) ? bmin : bmax;
        for (int r = 0; r < b; r++)
          for (int c = 0; c < b; c++) begin
            row = bi*b + r; col = bj*b + c;
            w = (row < nw && col < nw) ? w_img[row*nw + col] : 0;
            v = (alpha * p_img[row*np + col] + beta * w) / 100;
            if (v > iwhite) v = iwhite;
            exp_q.push_back(v);
          end
      end
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (Image_Done) begin timed_out = 0; break; end
    end
  endtask

  task automatic start_and_wait(output bit timed_out);
    got_q.delete();
    apb_write(0, 1);
    wait_done(timed_out);
  endtask

  task automatic test_reset();
    int d;
    repeat (3) @(negedge clk);
    n_cmp++; if ({Pixel_Data, new_pixel, Image_Done} !== 10'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", {Pixel_Data, new_pixel, Image_Done});
    end
    n_cmp++; if (PRDATA !== 16'd0) begin n_err++; $display("FAIL reset_prdata: got %0d expected 0", PRDATA); end
    rst = 1;
    apb_read(2, d);
    n_cmp++; if (d !== 0) begin n_err++; $display("FAIL reset_np_reg: got %0d expected 0", d); end
  endtask

  task automatic test_flat();
    bit to;
    set_common(); load_params();
    for (int i = 0; i < 16; i++) begin p_img[i] = 100; w_img[i] = 0; end
    load_images(); build_model();
    start_and_wait(to);
    n_cmp++; if (to !== 0) begin n_err++; $display("FAIL flat_done: got timeout expected Image_Done"); end
    n_cmp++; if (got_q.size() !== 16) begin n_err++; $display("FAIL flat_count: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      n_cmp++; if (got_q[i] !== 88) begin n_err++; $display("FAIL flat_pix[%0d]: got %0d expected 88", i, got_q[i]); end
    end
  endtask

  task automatic test_saturate();
    bit to;
    int lim[2] = '{249, 200};
    for (int i = 0; i < 16; i++) begin p_img[i] = 200; w_img[i] = 255; end
    load_images();
    for (int k = 0; k < 2; k++) begin
      iwhite = (k == 0) ? 255 : 200;
      apb_write(1, iwhite);
      start_and_wait(to);
      n_cmp++; if (to !== 0 || got_q.size() !== 16) begin
        n_err++; $display("FAIL sat_count[%0d]: got %0d expected 16", k, got_q.size());
      end
      for (int i = 0; i < got_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== lim[k]) begin
          n_err++; $display("FAIL sat_pix[%0d][%0d]: got %0d expected %0d", k, i, got_q[i], lim[k]);
        end
      end
    end
  endtask

  task automatic test_block();
    bit to;
    int first[4] = '{31, 31, 31, 115};
    set_common(); load_params();
    for (int i = 0; i < 16; i++) begin p_img[i] = $urandom_range(0, 255); w_img[i] = 100; end
    p_img[0] = 0; p_img[1] = 0; p_img[4] = 0; p_img[5] = 100;
    load_images(); build_model();
    start_and_wait(to);
    n_cmp++; if (to !== 0 || got_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL block_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== first[i]) begin n_err++; $display("FAIL block0_pix[%0d]: got %0d expected %0d", i, got_q[i], first[i]); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL block_pix[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_readback();
    bit to;
    int d;
    apb_read(2, d);
    n_cmp++; if (d !== np) begin n_err++; $display("FAIL rd_np: got %0d expected %0d", d, np); end
    apb_read(10, d);
    n_cmp++; if (d !== p_img[0]) begin n_err++; $display("FAIL rd_p0: got %0d expected %0d", d, p_img[0]); end
    apb_read(15, d);
    n_cmp++; if (d !== p_img[5]) begin n_err++; $display("FAIL rd_p5: got %0d expected %0d", d, p_img[5]); end
    got_q.delete();
    apb_write(0, 1);
    apb_read(0, d);
    n_cmp++; if (d[1:0] !== 2'b10) begin n_err++; $display("FAIL rd_ctrl_busy: got %0d expected 2", d); end
    wait_done(to);
    apb_read(0, d);
    n_cmp++; if (to !== 0 || d[1:0] !== 2'b01) begin n_err++; $display("FAIL rd_ctrl_done: got %0d expected 1", d); end
  endtask

  task automatic test_random();
    bit to;
    for (int k = 0; k < 4; k++) begin
      m = $urandom_range(1, 3); np = m * $urandom_range(1, 4); nw = $urandom_range(0, np + 2);
      bthr = $urandom_range(0, 255); amin = $urandom_range(0, 200); amax = $urandom_range(amin, 255);
      bmin = $urandom_range(0, 255); bmax = $urandom_range(0, 255); iwhite = $urandom_range(100, 255);
      for (int i = 0; i < 256; i++) begin p_img[i] = $urandom_range(0, 255); w_img[i] = $urandom_range(0, 255); end
      load_params(); load_images(); build_model();
      start_and_wait(to);
      n_cmp++; if (to !== 0 || got_q.size() !== np*np) begin
        n_err++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", k, got_q.size(), np*np);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL rnd_pix[%0d][%0d]: got %0d expected %0d", k, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to, seen;
    int d;
    set_common(); load_params();
    for (int i = 0; i < 16; i++) begin p_img[i] = 100; w_img[i] = 0; end
    load_images(); build_model();
    apb_write(0, 1);
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin @(negedge clk); seen = new_pixel; end
    n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL mid_first_strobe: got none expected strobe"); end
    @(negedge clk);
    rst = 0;
    #1;
    n_cmp++; if ({Pixel_Data, new_pixel, Image_Done, PRDATA} !== 26'd0) begin
      n_err++; $display("FAIL mid_reset_outputs: got %h expected 0", {Pixel_Data, new_pixel, Image_Done, PRDATA});
    end
    @(negedge clk); rst = 1;
    apb_read(0, d);
    n_cmp++; if (d !== 0) begin n_err++; $display("FAIL mid_reset_idle: got %0d expected 0", d); end
    load_params();
    start_and_wait(to);
    n_cmp++; if (to !== 0 || got_q.size() !== 16) begin n_err++; $display("FAIL mid_restart_count: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_restart_pix[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_lock_and_empty();
    bit to;
    int d;
    got_q.delete();
    apb_write(0, 1);
    apb_write(10, 55);
    apb_write(2, 9);
    wait_done(to);
    n_cmp++; if (to !== 0 || got_q.size() !== 16) begin n_err++; $display("FAIL lock_count: got %0d expected 16", got_q.size()); end
    apb_read(10, d);
    n_cmp++; if (d !== p_img[0]) begin n_err++; $display("FAIL lock_bank: got %0d expected %0d", d, p_img[0]); end
    apb_read(2, d);
    n_cmp++; if (d !== 4) begin n_err++; $display("FAIL lock_reg: got %0d expected 4", d); end
    apb_write(2, 0);
    start_and_wait(to);
    repeat (4) @(negedge clk);
    n_cmp++; if (to !== 0 || Image_Done !== 1'b1) begin n_err++; $display("FAIL empty_done: got %0b expected 1", Image_Done); end
    n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL empty_count: got %0d expected 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_saturate();
    test_block();
    test_readback();
    test_random();
    test_reset_mid();
    test_lock_and_empty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
